mult_div_sequencer: RTL and testbench

- Iterative multiply/divide unit and its sequencer for the MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU over 33 cycles and owns the architectural HI/LO registers, including MTHI/MTLO writes.
- Drives the pipeline stall when an MFHI/MFLO reaches the unit while an operation is in flight.
- Sits in EX beside the ALU and is sequenced by the main control unit's Start/Op decode.

---
 rtl/mult_div_sequencer_if.sv | 28 ++
 rtl/mult_div_sequencer.sv | 178 +++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_sequencer_if.sv
// Handshake/data bundle between the EX-stage control and the multiply/divide unit.
// Signal suffixes are from the unit's point of view (_i into the unit, _o out of it).
interface mult_div_sequencer_if #(parameter int WIDTH = 32);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             hi_write_i;
    logic             lo_write_i;
    logic [WIDTH-1:0] write_data_i;
    logic             hilo_read_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             done_o;
    logic             div_by_zero_o;
    logic             stall_o;

    modport master (
        output start_i, op_i, a_i, b_i, hi_write_i, lo_write_i, write_data_i, hilo_read_i,
        input  hi_o, lo_o, busy_o, done_o, div_by_zero_o, stall_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, hi_write_i, lo_write_i, write_data_i, hilo_read_i,
        output hi_o, lo_o, busy_o, done_o, div_by_zero_o, stall_o
    );
endinterface

// File: rtl/mult_div_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; WIDTH iterations plus a sign-fix cycle.
// Define MULTDIV_DIV_EN to build the restoring-divide datapath; otherwise divide starts are ignored.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst,
    mult_div_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_res_q, neg_res_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op, accept;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;

    assign signed_op = ~bus.op_i[0];
    assign abs_a     = (signed_op && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
    assign abs_b     = (signed_op && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
    // acc holds {partial product, remaining multiplier bits}; shifts right each step
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign prod      = neg_res_q ? -acc_q : acc_q;

`ifdef MULTDIV_DIV_EN
    logic               is_div_q, is_div_d;
    logic               neg_rem_q, neg_rem_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [WIDTH-1:0]   quo, rem;

    // acc holds {partial remainder, dividend bits becoming quotient bits}
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign quo       = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem       = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign accept    = bus.start_i && (state_q == IDLE);
    assign bus.div_by_zero_o = dbz_q;
`else
    assign accept    = bus.start_i && (state_q == IDLE) && !bus.op_i[1];
    assign bus.div_by_zero_o = 1'b0;
`endif

    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.done_o  = done_q;
    assign bus.stall_o = bus.hilo_read_i & ((state_q != IDLE) | (bus.start_i & (state_q == IDLE)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MULTDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        a_raw_d   = a_raw_q;
        dbz_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = CALC;
                    cnt_d     = CW'(WIDTH - 1);
                    neg_res_d = signed_op & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
                    opnd_d    = abs_a;
                    acc_d     = {{WIDTH{1'b0}}, abs_b};
`ifdef MULTDIV_DIV_EN
                    is_div_d  = bus.op_i[1];
                    neg_rem_d = signed_op & bus.a_i[WIDTH-1];
                    b_zero_d  = (bus.b_i == '0);
                    a_raw_d   = bus.a_i;
                    if (bus.op_i[1]) begin
                        opnd_d = abs_b;
                        acc_d  = {{WIDTH{1'b0}}, abs_a};
                    end
`endif
                end else if (!bus.start_i) begin
                    if (bus.hi_write_i) hi_d = bus.write_data_i;
                    if (bus.lo_write_i) lo_d = bus.write_data_i;
                end
            end
            CALC: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
`ifdef MULTDIV_DIV_EN
                if (is_div_q) begin
                    if (div_diff[WIDTH])
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    else
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
`else
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`endif
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
`ifdef MULTDIV_DIV_EN
                dbz_d = is_div_q & b_zero_q;
                if (is_div_q) begin
                    // divide-by-zero bypasses sign correction entirely
                    if (b_zero_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

`ifdef MULTDIV_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            a_raw_q   <= '0;
            dbz_q     <= 1'b0;
        end else begin
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            a_raw_q   <= a_raw_d;
            dbz_q     <= dbz_d;
        end
    end
`endif
endmodule

// File: tb/tb_mult_div_sequencer.sv
// Randomized self-checking bench for mult_div_sequencer against a plain-arithmetic HI/LO model.
// Divide scenarios follow MULTDIV_DIV_EN the same way the design does.
module tb_mult_div_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_sequencer_if #(.WIDTH(W)) bus();
    mult_div_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint     sa, sb, sq, sr;
        logic [63:0] ua, ub, p, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        dbz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = ua * ub;      hi = p[63:32]; lo = p[31:0]; end
            2'd2: begin
                if (b == 0) begin hi = a; lo = '1; dbz = 1'b1; end
                else begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; dbz = 1'b1; end
                else begin uq = ua / ub; ur = ua % ub; lo = uq[31:0]; hi = ur[31:0]; end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Call at a negedge; returns at the negedge following the Start edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Counts Busy cycles from the negedge after Start; stops on the Done negedge.
    task automatic wait_done(output int busy_cycles, output bit ok);
        busy_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o) begin ok = 1'b1; break; end
            if (bus.busy_o) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi_o); end
        checks++; if (bus.lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo_o); end
        checks++; if ({bus.busy_o, bus.done_o, bus.div_by_zero_o, bus.stall_o} !== 4'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {bus.busy_o, bus.done_o, bus.div_by_zero_o, bus.stall_o}); end
        bus.hilo_read_i = 1'b1;
        bus.start_i = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL reset_stall_eq got=%b exp=1", bus.stall_o); end
        bus.hilo_read_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult_basic();
        int n; bit ok;
        start_op(2'd0, 32'hFFFF_FFFE, 32'd3);
        wait_done(n, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mult_timeout done never rose"); end
        checks++; if (n != 33) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=33", n); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL mult_busy_at_done got=%b exp=0", bus.busy_o); end
        checks++; if (bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFFA) begin
            failures++; $display("FAIL mult_neg2x3 got=%h_%h exp=ffffffff_fffffffa", bus.hi_o, bus.lo_o); end
        checks++; if (bus.div_by_zero_o !== 1'b0) begin failures++; $display("FAIL mult_dbz got=%b exp=0", bus.div_by_zero_o); end
        @(negedge clk);
        checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL mult_done_width got=%b exp=0", bus.done_o); end
        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, ok);
        checks++; if (!ok || bus.hi_o !== 32'hFFFF_FFFE || bus.lo_o !== 32'h0000_0001) begin
            failures++; $display("FAIL multu_max ok=%b got=%h_%h exp=fffffffe_00000001", ok, bus.hi_o, bus.lo_o); end
        @(negedge clk);
    endtask

`ifdef MULTDIV_DIV_EN
    task automatic test_div();
        int n; bit ok;
        start_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, ok);
        checks++; if (!ok || n != 33 || bus.lo_o !== 32'hFFFF_FFFD || bus.hi_o !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL div_neg7_2 ok=%b cyc=%0d got=%h_%h exp=ffffffff_fffffffd", ok, n, bus.hi_o, bus.lo_o); end
        @(negedge clk);
        start_op(2'd3, 32'd100, 32'd0);
        wait_done(n, ok);
        checks++; if (!ok || n != 33 || bus.lo_o !== 32'hFFFF_FFFF || bus.hi_o !== 32'd100 || bus.div_by_zero_o !== 1'b1) begin
            failures++; $display("FAIL divu_by_zero ok=%b cyc=%0d got=%h_%h dbz=%b exp=00000064_ffffffff dbz=1",
                                 ok, n, bus.hi_o, bus.lo_o, bus.div_by_zero_o); end
        @(negedge clk);
        checks++; if (bus.div_by_zero_o !== 1'b0) begin failures++; $display("FAIL dbz_width got=%b exp=0", bus.div_by_zero_o); end
        start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, ok);
        checks++; if (!ok || bus.lo_o !== 32'h8000_0000 || bus.hi_o !== 32'h0) begin
            failures++; $display("FAIL div_overflow ok=%b got=%h_%h exp=00000000_80000000", ok, bus.hi_o, bus.lo_o); end
        @(negedge clk);
    endtask
`else
    task automatic test_div();
        logic [31:0] hi0, lo0;
        bit saw_done, saw_busy;
        hi0 = bus.hi_o;
        lo0 = bus.lo_o;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        start_op(2'd3, 32'd100, 32'd0);
        for (int i = 0; i < 36; i++) begin
            if (bus.done_o) saw_done = 1'b1;
            if (bus.busy_o) saw_busy = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_busy) begin failures++; $display("FAIL divu_disabled_busy got=1 exp=0"); end
        checks++; if (saw_done) begin failures++; $display("FAIL divu_disabled_done got=1 exp=0"); end
        checks++; if (bus.hi_o !== hi0 || bus.lo_o !== lo0 || bus.div_by_zero_o !== 1'b0) begin
            failures++; $display("FAIL divu_disabled_hilo got=%h_%h exp=%h_%h", bus.hi_o, bus.lo_o, hi0, lo0); end
    endtask
`endif

    task automatic test_random();
        int n; bit ok;
        logic [1:0] op; logic [31:0] a, b, eh, el; logic ed;
        for (int k = 0; k < 24; k++) begin
`ifdef MULTDIV_DIV_EN
            op = 2'($urandom_range(0, 3));
`else
            op = 2'($urandom_range(0, 1));
`endif
            a = pick();
            b = pick();
            model(op, a, b, eh, el, ed);
            start_op(op, a, b);
            wait_done(n, ok);
            checks++; if (!ok || n != 33 || bus.hi_o !== eh || bus.lo_o !== el || bus.div_by_zero_o !== ed) begin
                failures++; $display("FAIL random op=%0d a=%h b=%h ok=%b cyc=%0d got=%h_%h/%b exp=%h_%h/%b",
                                     op, a, b, ok, n, bus.hi_o, bus.lo_o, bus.div_by_zero_o, eh, el, ed); end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n; bit ok;
        logic [31:0] a1, b1, a2, b2, eh, el; logic ed;
        a1 = $urandom(); b1 = $urandom(); a2 = $urandom(); b2 = $urandom();
        start_op(2'd0, a1, b1);
        wait_done(n, ok);
        model(2'd0, a1, b1, eh, el, ed);
        checks++; if (!ok || bus.hi_o !== eh || bus.lo_o !== el) begin
            failures++; $display("FAIL b2b_first ok=%b got=%h_%h exp=%h_%h", ok, bus.hi_o, bus.lo_o, eh, el); end
        start_op(2'd1, a2, b2);
        wait_done(n, ok);
        model(2'd1, a2, b2, eh, el, ed);
        checks++; if (!ok || n != 33 || bus.hi_o !== eh || bus.lo_o !== el) begin
            failures++; $display("FAIL b2b_second ok=%b cyc=%0d got=%h_%h exp=%h_%h", ok, n, bus.hi_o, bus.lo_o, eh, el); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int n, stall_low; bit ok;
        logic [31:0] a, b, eh, el; logic ed;
        a = $urandom(); b = $urandom();
        model(2'd1, a, b, eh, el, ed);
        bus.hilo_read_i = 1'b1;
        bus.start_i = 1'b1; bus.op_i = 2'd1; bus.a_i = a; bus.b_i = b;
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL stall_start_cycle got=%b exp=1", bus.stall_o); end
        @(negedge clk);
        bus.start_i = 1'b0;
        n = 0; ok = 1'b0; stall_low = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o) begin ok = 1'b1; break; end
            if (bus.busy_o) n++;
            if (!bus.stall_o) stall_low++;
            if (i == 4) begin
                bus.start_i = 1'b1; bus.op_i = 2'd0; bus.a_i = 32'd7; bus.b_i = 32'd9;
                bus.hi_write_i = 1'b1; bus.write_data_i = 32'hDEAD_BEEF;
            end
            if (i == 5) begin bus.start_i = 1'b0; bus.hi_write_i = 1'b0; end
            @(negedge clk);
        end
        checks++; if (stall_low != 0) begin failures++; $display("FAIL stall_busy low_cycles=%0d exp=0", stall_low); end
        checks++; if (!ok || n != 33) begin failures++; $display("FAIL stall_busy_len ok=%b got=%0d exp=33", ok, n); end
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL stall_done_cycle got=%b exp=0", bus.stall_o); end
        checks++; if (bus.hi_o !== eh || bus.lo_o !== el) begin
            failures++; $display("FAIL busy_ignores got=%h_%h exp=%h_%h", bus.hi_o, bus.lo_o, eh, el); end
        bus.hilo_read_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        start_op(2'd0, 32'h0012_3456, 32'hFFFF_F777);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0 || bus.busy_o !== 1'b0) begin
            failures++; $display("FAIL abort_state got=%h_%h busy=%b exp=0_0 busy=0", bus.hi_o, bus.lo_o, bus.busy_o); end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o || bus.busy_o) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_done) begin failures++; $display("FAIL abort_no_done got=1 exp=0"); end
        bus.lo_write_i = 1'b1; bus.write_data_i = 32'h0000_1234;
        @(negedge clk);
        bus.lo_write_i = 1'b0;
        checks++; if (bus.lo_o !== 32'h0000_1234 || bus.hi_o !== 32'h0) begin
            failures++; $display("FAIL mtlo got=%h_%h exp=00000000_00001234", bus.hi_o, bus.lo_o); end
        bus.hi_write_i = 1'b1; bus.lo_write_i = 1'b1; bus.write_data_i = 32'hA5A5_0F0F;
        @(negedge clk);
        bus.hi_write_i = 1'b0; bus.lo_write_i = 1'b0;
        checks++; if (bus.lo_o !== 32'hA5A5_0F0F || bus.hi_o !== 32'hA5A5_0F0F) begin
            failures++; $display("FAIL mthi_mtlo got=%h_%h exp=a5a50f0f_a5a50f0f", bus.hi_o, bus.lo_o); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b0; bus.op_i = 2'd0; bus.a_i = '0; bus.b_i = '0;
        bus.hi_write_i = 1'b0; bus.lo_write_i = 1'b0; bus.write_data_i = '0; bus.hilo_read_i = 1'b0;
        test_reset();
        test_mult_basic();
        test_div();
        test_random();
        test_back_to_back();
        test_stall();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
